cbus_rr_arbiter: RTL and testbench



---
 rtl/cbus_rr_arbiter_if.sv | 44 ++++
 rtl/cbus_rr_arbiter.sv | 84 ++++++++
 tb/tb_cbus_rr_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_if.sv
// CBus request/response types and the arbiter's port bundle.
// Requesters and the external bus share one interface instance.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

interface cbus_rr_arbiter_if #(
  parameter int N = 2
);
  import cbus_pkg::*;

  cbus_req_t  [N-1:0] ireqs;
  cbus_resp_t [N-1:0] iresps;
  cbus_req_t          oreq;
  cbus_resp_t         oresp;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );
endinterface

// File: rtl/cbus_rr_arbiter.sv
// Round-robin CBus arbiter: one grant per burst, held until the last
// beat is accepted; rotation starts after the last completed grant.
module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input logic              clk,
  input logic              reset,
  cbus_rr_arbiter_if.slave bus
);
  localparam int W = $clog2(NUM_INPUTS);
  localparam logic [W-1:0] MAX = W'(NUM_INPUTS - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t       state;
  state_t       state_n;
  logic [W-1:0] idx;
  logic [W-1:0] idx_n;
  logic [W-1:0] last_idx;
  logic [W-1:0] last_idx_n;
  logic [W-1:0] pick;
  logic         hit;

  // Wrap by compare so non-power-of-two counts never reach MAX+1.
  always_comb begin : scan
    logic [W-1:0] c;
    c    = last_idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      c = (c == MAX) ? '0 : c + 1'b1;
      if (!hit && bus.ireqs[c].valid) begin
        hit  = 1'b1;
        pick = c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= MAX;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      last_idx <= last_idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    last_idx_n = last_idx;
    bus.oreq   = '0;
    bus.iresps = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_n = BUSY;
          idx_n   = pick;
        end
      end
      BUSY: begin
        bus.iresps[idx] = bus.oresp;
        // A withdrawn requester frees the bus without moving the pointer.
        if (!bus.ireqs[idx].valid) begin
          state_n = IDLE;
        end else begin
          bus.oreq = bus.ireqs[idx];
          if (bus.oresp.ready && bus.oresp.last) begin
            state_n    = IDLE;
            last_idx_n = idx;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: vector table on a 2-input
// instance plus burst-lock, reset and wrap sequences.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   tag = 0;

  always #5 clk = ~clk;

  cbus_rr_arbiter_if #(.N(2)) b2 ();
  cbus_rr_arbiter_if #(.N(3)) b3 ();

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (b2.slave)
  );

  cbus_rr_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (b3.slave)
  );

  typedef struct {
    bit rst;
    bit v0;
    bit v1;
    bit rdy;
    bit lst;
    int own;
  } vec_t;

  vec_t tv[$];

  function automatic cbus_req_t tmpl(int i);
    cbus_req_t t;
    t          = '0;
    t.valid    = 1'b1;
    t.is_write = i[0];
    t.size     = 3'd2;
    t.addr     = 32'(32'h1000 * (i + 1));
    t.strobe   = 4'hf;
    t.data     = 32'(32'hA0 + i);
    t.len      = 8'(i + 3);
    return t;
  endfunction

  function automatic cbus_req_t req(int i, bit v);
    cbus_req_t t;
    t       = tmpl(i);
    t.valid = v;
    return t;
  endfunction

  function automatic cbus_resp_t rsp(bit rdy, bit lst);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = rdy ? 32'(32'hD000 + tag) : 32'h0;
    return r;
  endfunction

  function automatic void add(bit rst, bit v0, bit v1,
                              bit rdy, bit lst, int own);
    tv.push_back('{rst, v0, v1, rdy, lst, own});
  endfunction

  task automatic run2(bit rst, bit v0, bit v1, bit rdy,
                      bit lst, int own, string nm);
    cbus_req_t            er;
    cbus_resp_t [1:0]     ep;
    @(negedge clk);
    tag++;
    reset       = rst;
    b2.ireqs[0] = req(0, v0);
    b2.ireqs[1] = req(1, v1);
    b2.oresp    = rsp(rdy, lst);
    #1;
    er = '0;
    ep = '0;
    if (own >= 0) begin
      er      = tmpl(own);
      ep[own] = b2.oresp;
    end
    checks++;
    if (b2.oreq !== er) begin
      failures++;
      $display("FAIL %s oreq got=%h exp=%h", nm, b2.oreq, er);
    end
    checks++;
    if (b2.iresps !== ep) begin
      failures++;
      $display("FAIL %s iresps got=%h exp=%h", nm, b2.iresps, ep);
    end
  endtask

  task automatic run3(bit v0, bit v1, bit v2, bit rdy,
                      bit lst, int own, string nm);
    cbus_req_t        er;
    cbus_resp_t [2:0] ep;
    @(negedge clk);
    tag++;
    reset       = 1'b0;
    b3.ireqs[0] = req(0, v0);
    b3.ireqs[1] = req(1, v1);
    b3.ireqs[2] = req(2, v2);
    b3.oresp    = rsp(rdy, lst);
    #1;
    er = '0;
    ep = '0;
    if (own >= 0) begin
      er      = tmpl(own);
      ep[own] = b3.oresp;
    end
    checks++;
    if (b3.oreq !== er) begin
      failures++;
      $display("FAIL %s oreq got=%h exp=%h", nm, b3.oreq, er);
    end
    checks++;
    if (b3.iresps !== ep) begin
      failures++;
      $display("FAIL %s iresps got=%h exp=%h", nm, b3.iresps, ep);
    end
  endtask

  initial begin
    int b;
    bit rdy;
    b2.ireqs = '0;
    b2.oresp = '0;
    b3.ireqs = '0;
    b3.oresp = '0;

    // reset holds off a pending request, then a single-beat grant to 1
    add(1, 0, 1, 0, 0, -1);
    add(0, 0, 1, 0, 0, -1);
    add(0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, -1);
    // both requesting: 4-beat bursts granted 0,1,0,1
    for (int g = 0; g < 4; g++) begin
      add(0, 1, 1, 0, 0, -1);
      for (int k = 0; k < 3; k++) add(0, 1, 1, 1, 0, g % 2);
      add(0, 1, 1, 1, 1, g % 2);
    end
    add(0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, -1);
    add(0, 1, 0, 1, 1, 0);
    // requester 1 granted then withdraws; pointer stays at 0
    add(0, 0, 1, 0, 0, -1);
    add(0, 0, 0, 0, 0, -1);
    add(0, 1, 1, 0, 0, -1);
    add(0, 1, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, -1);

    repeat (2) @(posedge clk);
    foreach (tv[i])
      run2(tv[i].rst, tv[i].v0, tv[i].v1, tv[i].rdy,
           tv[i].lst, tv[i].own, $sformatf("row%0d", i));

    // burst lock: 16 beats, ready every other cycle
    run2(0, 1, 0, 0, 0, -1, "bl_idle");
    b = 0;
    for (int c = 0; c < 40 && b < 16; c++) begin
      rdy = (c % 2) == 1;
      run2(0, 1, b >= 2, rdy, rdy && b == 15, 0,
           $sformatf("bl_beat%0d", b));
      if (rdy) b++;
    end
    run2(0, 0, 1, 0, 0, -1, "bl_gap");
    run2(0, 0, 1, 1, 1, 1, "bl_next");

    // mid-burst reset restores the pointer to the last slot
    run2(0, 1, 0, 0, 0, -1, "pre_idle");
    run2(0, 1, 0, 1, 1, 0, "pre_beat");
    run2(0, 0, 1, 0, 0, -1, "rst_idle");
    run2(0, 0, 1, 1, 0, 1, "rst_b1");
    run2(1, 0, 1, 1, 0, 1, "rst_b2");
    run2(0, 1, 1, 0, 0, -1, "rst_after");
    run2(0, 1, 1, 1, 1, 0, "rst_regrant");
    run2(0, 0, 0, 0, 0, -1, "rst_end");

    // three inputs: wrap from slot 2 to 0, then 0 skips 1 to reach 2
    run3(1, 0, 1, 0, 0, -1, "wr_idle0");
    run3(1, 0, 1, 1, 1, 0, "wr_g0");
    run3(1, 0, 1, 0, 0, -1, "wr_idle1");
    run3(1, 0, 1, 1, 1, 2, "wr_g2");
    run3(0, 0, 0, 0, 0, -1, "wr_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
